// File: rtl/sdram_ctrl16.sv
// sdram_ctrl16 -- single-word 16-bit SDR SDRAM controller on clk_cpu.
//
// Handles power-up initialisation, periodic auto-refresh and arbitration
// between the main request port and an optional read-only ROM port. Every
// access is one ACTIVATE, then one READ/WRITE with auto-precharge.
//
// Build option: define SDRC_ROM_PORT_EN to enable the ROM read port. When
// it is undefined, the ROM ports are still present: rom_oe and rom_addr are
// ignored, and rom_dout and rom_ack are held at 0.
//
// Ports:
//   clk_cpu, reset                 clock; synchronous active-high reset
//   req, we, addr, din, ds         main port request (one-cycle req pulse)
//   dout, ack, busy, init_done     main port read data and status
//   rom_oe, rom_addr               ROM port request (rising edge of rom_oe)
//   rom_dout, rom_ack              ROM port read data and completion
//   sd_cs/ras/cas/we, sd_ba,       SDRAM command, bank and address
//   sd_addr
//   sd_dqm, sd_data_out,           SDRAM byte mask and write data
//   sd_data_wr
//   sd_data_in                     SDRAM read data
//
// state     | meaning
// INIT_WAIT | power-up NOPs
// INIT_PRE  | PRECHARGE ALL + 1 NOP
// INIT_REF1 | first AUTO REFRESH + TRFC NOPs
// INIT_REF2 | second AUTO REFRESH + TRFC NOPs
// INIT_MRS  | mode register set + NOP
// IDLE      | arbitrate: refresh > main > ROM
// ACTIVATE  | ACT on pins (row open)
// RW        | READ/WRITE with auto-precharge on pins
// WAIT      | NOPs until write done / read data sampled
// REFRESH   | AUTO REFRESH + NOPs
module sdram_ctrl16 #(
  parameter int CAS_LAT        = 2,
  parameter int INIT_CYCLES    = 5000,
  parameter int REFRESH_CYCLES = 190,
  parameter int TRFC           = 3
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [23:0] addr,
  input  logic [15:0] din,
  input  logic [1:0]  ds,
  output logic [15:0] dout,
  output logic        ack,
  output logic        busy,
  output logic        init_done,
  input  logic        rom_oe,
  input  logic [23:0] rom_addr,
  output logic [15:0] rom_dout,
  output logic        rom_ack,
  output logic        sd_cs,
  output logic        sd_ras,
  output logic        sd_cas,
  output logic        sd_we,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_addr,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_data_out,
  output logic        sd_data_wr,
  input  logic [15:0] sd_data_in
);

  localparam int CNT_W = 16;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [2:0]  CL_BITS  = 3'(CAS_LAT);
  localparam logic [12:0] MODE_REG = {3'b000, 1'b1, 2'b00, CL_BITS, 4'b0000};

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, ACTIVATE, RW, WAIT, REFRESH
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [3:0]         cmd, cmd_n;
  logic [1:0]         ba_n;
  logic [12:0]        a_n;
  logic [1:0]         dqm_n;
  logic               dwr_n;
  logic [15:0]        dout_sd_n;
  logic               init_done_n;
  logic               done, launch, launch_rom, ref_clr;

  logic [CNT_W-1:0]   ref_cnt;
  logic               ref_due;

  logic               main_full, m_we;
  logic [23:0]        m_addr;
  logic [15:0]        m_din;
  logic [1:0]         m_ds;
  logic               main_pend, sel_we;
  logic [23:0]        sel_addr, acc_addr;
  logic [15:0]        sel_din;
  logic [1:0]         sel_ds;

  logic               cur_rom, cur_we;
  logic [8:0]         cur_col;
  logic [15:0]        cur_din;
  logic [1:0]         cur_ds;

  logic               rom_pend;
  logic [23:0]        rom_slot_addr;

  assign {sd_cs, sd_ras, sd_cas, sd_we} = cmd;

  // A request can launch in the same cycle it arrives, before it has
  // landed in the slot, so the slot contents are bypassed while empty.
  assign main_pend = main_full | (req & ~busy);
  assign sel_we    = main_full ? m_we   : we;
  assign sel_addr  = main_full ? m_addr : addr;
  assign sel_din   = main_full ? m_din  : din;
  assign sel_ds    = main_full ? m_ds   : ds;
  assign acc_addr  = main_pend ? sel_addr : rom_slot_addr;

  // busy also covers the ack cycle; the slot itself empties one cycle
  // earlier so IDLE cannot relaunch the finished request.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      main_full <= 1'b0;
      busy      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_din     <= '0;
      m_ds      <= '0;
    end else begin
      if (req && !busy) begin
        main_full <= 1'b1;
        busy      <= 1'b1;
        m_we      <= we;
        m_addr    <= addr;
        m_din     <= din;
        m_ds      <= ds;
      end
      if (done && !cur_rom) main_full <= 1'b0;
      if (ack) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      ref_cnt <= '0;
      ref_due <= 1'b0;
    end else begin
      if (ref_clr) ref_due <= 1'b0;
      if (init_done) begin
        if (ref_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
          ref_cnt <= '0;
          ref_due <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 16'd1;
        end
      end
    end
  end

`ifdef SDRC_ROM_PORT_EN
  logic rom_oe_q, rom_full;

  assign rom_pend = rom_full;

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      rom_oe_q      <= 1'b0;
      rom_full      <= 1'b0;
      rom_slot_addr <= '0;
      rom_ack       <= 1'b0;
      rom_dout      <= '0;
    end else begin
      rom_oe_q <= rom_oe;
      if (rom_oe && !rom_oe_q && !rom_full) begin
        rom_full      <= 1'b1;
        rom_slot_addr <= rom_addr;
      end
      if (done && cur_rom) begin
        rom_full <= 1'b0;
        rom_dout <= sd_data_in;
      end
      rom_ack <= done & cur_rom;
    end
  end
`else
  logic rom_unused;
  assign rom_unused    = ^{rom_oe, rom_addr};
  assign rom_pend      = 1'b0;
  assign rom_slot_addr = '0;
  assign rom_dout      = '0;
  assign rom_ack       = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_n       = CMD_NOP;
    ba_n        = sd_ba;
    a_n         = sd_addr;
    dqm_n       = 2'b11;
    dwr_n       = 1'b0;
    dout_sd_n   = sd_data_out;
    init_done_n = init_done;
    done        = 1'b0;
    launch      = 1'b0;
    launch_rom  = 1'b0;
    ref_clr     = 1'b0;
    case (state)
      INIT_WAIT: begin
        if (cnt == '0) begin
          state_n = INIT_PRE;
          cmd_n   = CMD_PRE;
          a_n     = 13'h0400;
          cnt_n   = CNT_W'(1);
        end else cnt_n = cnt - 16'd1;
      end
      INIT_PRE: begin
        if (cnt == '0) begin
          state_n = INIT_REF1;
          cmd_n   = CMD_REF;
          cnt_n   = CNT_W'(TRFC);
        end else cnt_n = cnt - 16'd1;
      end
      INIT_REF1: begin
        if (cnt == '0) begin
          state_n = INIT_REF2;
          cmd_n   = CMD_REF;
          cnt_n   = CNT_W'(TRFC);
        end else cnt_n = cnt - 16'd1;
      end
      INIT_REF2: begin
        if (cnt == '0) begin
          state_n = INIT_MRS;
          cmd_n   = CMD_MRS;
          ba_n    = 2'b00;
          a_n     = MODE_REG;
          cnt_n   = CNT_W'(1);
        end else cnt_n = cnt - 16'd1;
      end
      INIT_MRS: begin
        // The first IDLE cycle is the second NOP after MRS.
        if (cnt == '0) begin
          state_n     = IDLE;
          init_done_n = 1'b1;
        end else cnt_n = cnt - 16'd1;
      end
      IDLE: begin
        if (ref_due) begin
          // The IDLE cycle after REFRESH supplies the last of the TRFC NOPs.
          state_n = REFRESH;
          cmd_n   = CMD_REF;
          cnt_n   = CNT_W'(TRFC - 1);
          ref_clr = 1'b1;
        end else if (main_pend || rom_pend) begin
          state_n    = ACTIVATE;
          cmd_n      = CMD_ACT;
          ba_n       = acc_addr[23:22];
          a_n        = acc_addr[21:9];
          launch     = 1'b1;
          launch_rom = ~main_pend;
        end
      end
      ACTIVATE: begin
        state_n = RW;
        a_n     = {2'b00, 1'b1, 1'b0, cur_col};
        if (cur_we) begin
          cmd_n     = CMD_WRITE;
          dwr_n     = 1'b1;
          dout_sd_n = cur_din;
          dqm_n     = ~cur_ds;
          cnt_n     = '0;
        end else begin
          cmd_n = CMD_READ;
          dqm_n = 2'b00;
          cnt_n = CNT_W'(CAS_LAT);
        end
      end
      RW: begin
        state_n = WAIT;
        dqm_n   = cur_we ? 2'b11 : 2'b00;
      end
      WAIT: begin
        dqm_n = cur_we ? 2'b11 : 2'b00;
        // Read data is sampled one cycle after CAS latency expires.
        if (cnt == '0) begin
          state_n = IDLE;
          done    = 1'b1;
        end else cnt_n = cnt - 16'd1;
      end
      REFRESH: begin
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - 16'd1;
      end
      default: state_n = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state       <= INIT_WAIT;
      cnt         <= CNT_W'(INIT_CYCLES - 1);
      cmd         <= 4'b1111;
      sd_ba       <= '0;
      sd_addr     <= '0;
      sd_dqm      <= 2'b11;
      sd_data_wr  <= 1'b0;
      sd_data_out <= '0;
      init_done   <= 1'b0;
      dout        <= '0;
      ack         <= 1'b0;
      cur_rom     <= 1'b0;
      cur_we      <= 1'b0;
      cur_col     <= '0;
      cur_din     <= '0;
      cur_ds      <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cmd         <= cmd_n;
      sd_ba       <= ba_n;
      sd_addr     <= a_n;
      sd_dqm      <= dqm_n;
      sd_data_wr  <= dwr_n;
      sd_data_out <= dout_sd_n;
      init_done   <= init_done_n;
      ack         <= done & ~cur_rom;
      if (done && !cur_rom && !cur_we) dout <= sd_data_in;
      if (launch) begin
        cur_rom <= launch_rom;
        cur_we  <= launch_rom ? 1'b0 : sel_we;
        cur_col <= acc_addr[8:0];
        cur_din <= sel_din;
        cur_ds  <= sel_ds;
      end
    end
  end

endmodule
